// File: rtl/sub512_seq.sv
// Sequential W-bit subtractor: D = A - B - Bin, one SLICE-bit lookahead adder
// reused over NSLICE cycles, with valid/ready handshakes on input and output.
module sub512_seq #(
    parameter int W      = 512,
    parameter int SLICE  = 64,
    parameter int NSLICE = W / SLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] D,
    output logic         Bout,
    output logic         Z
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic            carry;
    logic            zacc;
    logic [IW-1:0]   idx;
    logic [SLICE-1:0] a_s, b_s, slice_sum;
    logic            slice_cout;
    logic            last;

    // Parallel-prefix (Kogge-Stone) adder: carry-in folded into bit 0's generate.
    function automatic logic [SLICE:0] cla_add(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             cin);
        logic [SLICE-1:0] g, p, gk, pk;
        logic [SLICE:0]   c;
        g     = x & y;
        p     = x ^ y;
        gk    = g;
        pk    = p;
        gk[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < SLICE; d = d * 2) begin
            // Descending so gk[i-d] still holds the previous level's value.
            for (int i = SLICE - 1; i >= d; i--) begin
                gk[i] = gk[i] | (pk[i] & gk[i-d]);
                pk[i] = pk[i] & pk[i-d];
            end
        end
        c[0]       = cin;
        c[SLICE:1] = gk;
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    assign a_s  = a_reg[idx*SLICE +: SLICE];
    assign b_s  = b_reg[idx*SLICE +: SLICE];
    assign last = (idx == IW'(NSLICE - 1));
    assign {slice_cout, slice_sum} = cla_add(a_s, ~b_s, carry);

    // Handshake outputs depend on state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are plain flops, not RAM,
            // so they are cleared by reset along with the control state.
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            zacc  <= 1'b0;
            idx   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            Z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= ~Bin;
                        idx   <= '0;
                        zacc  <= 1'b0;
                    end
                end
                RUN: begin
                    D[idx*SLICE +: SLICE] <= slice_sum;
                    carry <= slice_cout;
                    zacc  <= zacc | (|slice_sum);
                    idx   <= idx + 1'b1;
                    if (last) begin
                        Bout <= ~slice_cout;
                        Z    <= ~(zacc | (|slice_sum));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sub512_seq.md
# sub512_seq

Sequential 512-bit subtractor computing D = A − B − Bin with one 64-bit carry-lookahead adder slice reused over eight cycles. It is the inverse-direction companion of the 64-bit CLA adder path in the MAC_512 datapath, serving accumulator correction and operand comparison. It presents a valid/ready handshake on both sides and returns the difference, the borrow-out and a zero flag.

## Interface

**Parameters**
- W, 512, operand and result width.
- SLICE, 64, slice width processed per cycle. W must be an integer multiple of SLICE.
- NSLICE, W/SLICE = 8, derived number of slices.

**Ports**
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- in_valid, input, 1, operands presented.
- in_ready, output, 1, block can accept operands.
- A, input, W, minuend, unsigned.
- B, input, W, subtrahend, unsigned.
- Bin, input, 1, borrow-in.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- D, output, W, difference A − B − Bin mod 2^W.
- Bout, output, 1, borrow-out. It is 1 iff A < B + Bin, unsigned.
- Z, output, 1, 1 iff D == 0.

## Operation

**State machine: IDLE, RUN, DONE.**
- **IDLE**
  - in_ready = 1, out_valid = 0.
  - On in_valid at an edge:
    - latch A and B into internal registers;
    - carry ← ~Bin, idx ← 0, zacc ← 0;
    - go to RUN.
- **RUN**
  - in_ready = 0, out_valid = 0. Each edge processes slice idx:
    - sum = A[idx] + ~B[idx] + carry, over SLICE bits plus carry-out;
    - D[idx] ← sum, carry ← carry-out;
    - zacc ← zacc | (|sum);
    - idx ← idx + 1.
  - On the edge processing idx = NSLICE−1:
    - Bout ← ~carry-out of that slice;
    - Z ← ~(zacc | (|sum));
    - go to DONE.
- **DONE**
  - out_valid = 1, in_ready = 0.
  - D, Bout and Z are held stable.
  - On out_ready at an edge, go to IDLE.

**Arithmetic rules**
- Two's-complement subtraction. Carry-in to slice 0 is ~Bin.
- Borrow-out is the inverted final carry.
- No sign interpretation is applied to the operands.

**Boundary conditions**
- in_valid is ignored outside IDLE. Operands are sampled only at the accepting edge.
- Input A and B may change after acceptance without affecting the result.
- out_ready is ignored outside DONE.
- In DONE with out_ready held low indefinitely, outputs stay frozen and the block accepts nothing.
- D slices not yet written during RUN keep their previous values. D is only defined while out_valid = 1.
- Reset asserted in any state, including mid-RUN:
  - the operation is aborted and no result is produced;
  - all registers return to their reset values immediately, without waiting for clk.

**Reset values**
- state = IDLE, so in_ready = 1.
- out_valid = 0.
- D = 0, Bout = 0, Z = 0.
- idx = 0, carry = 0, zacc = 0.
- Internal operand registers = 0.

## Timing

- in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Latency:
  - the accepting edge is edge 0;
  - slices 0..7 are written at edges 1..8;
  - out_valid is high from edge 8.
- Result handshake completes at the first edge with out_valid & out_ready. The block is in IDLE (in_ready = 1) after that edge.
- Minimum issue interval is 10 cycles: accept, 8 RUN edges, DONE handshake edge, then next accept.
- The carry register and the SLICE-bit adder form the only arithmetic path. The critical path is one 64-bit CLA plus a mux, independent of W.

## Test plan

1. **Basic subtraction.** A = 5, B = 3, Bin = 0, out_ready = 1.
   - D = 2, Bout = 0, Z = 0.
   - out_valid rises exactly 8 edges after acceptance and lasts 1 cycle.
2. **Full borrow ripple.** A = 0, B = 1, Bin = 0.
   - D = 2^512 − 1 (all ones), Bout = 1, Z = 0.
   - The borrow crosses all 8 slice boundaries.
3. **Equal operands.** A = B = 0x0123…CDEF repeated.
   - With Bin = 0: D = 0, Z = 1, Bout = 0.
   - Rerun with Bin = 1: D = all ones, Z = 0, Bout = 1.
4. **Slice boundary.** A = 2^64, B = 1.
   - D[63:0] = all ones, D[127:64] = 0, D[511:128] = 0, Bout = 0.
   - Repeat with A = 2^448, B = 1: all ones up to bit 447, Bout = 0.
5. **Backpressure and stale input.**
   - Hold out_ready = 0 for 5 cycles after out_valid, while toggling in_valid and changing A and B.
   - D, Bout and Z must stay stable, in_ready must stay 0, and no new operation may start.
   - Raise out_ready: IDLE after 1 edge, and the next accept behaves correctly.
6. **Reset mid-operation.** Assert rst_n = 0 between clock edges while idx = 4.
   - Immediately: out_valid = 0, in_ready = 1, D = 0, Bout = 0, Z = 0.
   - After release, A = 10, B = 7 yields D = 3, Bout = 0.
